// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types and default sizing for the register-file
// write sequencer and its arbiter.
//   - state_t   : sequencer FSM states
//   - DEF_*     : default parameter values
//   - REQ_A/B   : requester index encoding used by the last-grant pointer
package regfile_pkg;

   typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

   localparam int DEF_DATA_W   = 8;
   localparam int DEF_ADDR_W   = 3;
   localparam int DEF_NUM_REGS = 8;

   localparam logic REQ_A = 1'b0;
   localparam logic REQ_B = 1'b1;

endpackage

// File: rtl/regfile_write_sequencer_rr_arbiter2.sv
// rr_arbiter2: combinational two-way round-robin grant.
// Ports:
//   a_valid, b_valid : requests
//   last_grant       : requester granted most recently (REQ_A / REQ_B)
//   enable           : grants are suppressed when low
//   grant_a, grant_b : one-hot (or zero) grant
// The last-grant register lives in the parent.
module rr_arbiter2
   import regfile_pkg::*;
(
   input  logic a_valid,
   input  logic b_valid,
   input  logic last_grant,
   input  logic enable,
   output logic grant_a,
   output logic grant_b
);

   // On contention the requester not granted last wins.
   logic a_wins;
   assign a_wins  = a_valid & (~b_valid | (last_grant == REQ_B));

   assign grant_a = enable & a_wins;
   assign grant_b = enable & b_valid & ~a_wins;

endmodule

// File: rtl/regfile_write_sequencer.sv
// regfile_write_sequencer: owns the register file's single write port.
// After reset (or Init_Start in RUN) it writes reg i <= i for all regs,
// then arbitrates writes from requesters A and B round-robin.
// Ports:
//   Clk, Reset (async, active-low)
//   Init_Start                       : request re-initialisation (RUN only)
//   A_Valid/A_Reg/A_Data, A_Ready    : requester A handshake
//   B_Valid/B_Reg/B_Data, B_Ready    : requester B handshake
//   RegWrite/Write_Reg_Num/Write_Data: registered register-file write port
//   Init_Busy                        : high while initialising
module regfile_write_sequencer
   import regfile_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int NUM_REGS = DEF_NUM_REGS
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              Init_Start,
   input  logic              A_Valid,
   input  logic [ADDR_W-1:0] A_Reg,
   input  logic [DATA_W-1:0] A_Data,
   output logic              A_Ready,
   input  logic              B_Valid,
   input  logic [ADDR_W-1:0] B_Reg,
   input  logic [DATA_W-1:0] B_Data,
   output logic              B_Ready,
   output logic              RegWrite,
   output logic [ADDR_W-1:0] Write_Reg_Num,
   output logic [DATA_W-1:0] Write_Data,
   output logic              Init_Busy
);

   localparam logic [ADDR_W-1:0] LAST_REG = ADDR_W'(NUM_REGS - 1);

   state_t            state;
   logic [ADDR_W-1:0] cnt;
   logic              last_grant;
   logic              grant_a, grant_b;
   logic              arb_en;

   // An Init_Start in RUN blocks acceptance so no write is lost to INIT.
   assign arb_en    = (state == ST_RUN) & ~Init_Start;
   assign Init_Busy = (state == ST_INIT);
   assign A_Ready   = grant_a;
   assign B_Ready   = grant_b;

   rr_arbiter2 u_arb (
      .a_valid    (A_Valid),
      .b_valid    (B_Valid),
      .last_grant (last_grant),
      .enable     (arb_en),
      .grant_a    (grant_a),
      .grant_b    (grant_b)
   );

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state         <= ST_INIT;
         cnt           <= '0;
         last_grant    <= REQ_B;
         RegWrite      <= 1'b0;
         Write_Reg_Num <= '0;
         Write_Data    <= '0;
      end else begin
         case (state)
            ST_INIT: begin
               RegWrite      <= 1'b1;
               Write_Reg_Num <= cnt;
               Write_Data    <= DATA_W'(cnt);
               if (cnt == LAST_REG) begin
                  state <= ST_RUN;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_RUN: begin
               if (Init_Start) begin
                  state    <= ST_INIT;
                  cnt      <= '0;
                  RegWrite <= 1'b0;
               end else if (grant_a & A_Valid) begin
                  RegWrite      <= 1'b1;
                  Write_Reg_Num <= A_Reg;
                  Write_Data    <= A_Data;
                  last_grant    <= REQ_A;
               end else if (grant_b & B_Valid) begin
                  RegWrite      <= 1'b1;
                  Write_Reg_Num <= B_Reg;
                  Write_Data    <= B_Data;
                  last_grant    <= REQ_B;
               end else begin
                  // Address/data hold; only the strobe drops.
                  RegWrite <= 1'b0;
               end
            end
            default: state <= ST_INIT;
         endcase
      end
   end

endmodule

// File: tb/tb_regfile_write_sequencer.sv
module tb_regfile_write_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       init_start;
   logic       a_valid, b_valid;
   logic [2:0] a_reg, b_reg;
   logic [7:0] a_data, b_data;
   logic       a_ready, b_ready;
   logic       regwrite;
   logic [2:0] wnum;
   logic [7:0] wdata;
   logic       init_busy;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   regfile_write_sequencer dut (
      .Clk           (clk),
      .Reset         (rst_n),
      .Init_Start    (init_start),
      .A_Valid       (a_valid),
      .A_Reg         (a_reg),
      .A_Data        (a_data),
      .A_Ready       (a_ready),
      .B_Valid       (b_valid),
      .B_Reg         (b_reg),
      .B_Data        (b_data),
      .B_Ready       (b_ready),
      .RegWrite      (regwrite),
      .Write_Reg_Num (wnum),
      .Write_Data    (wdata),
      .Init_Busy     (init_busy)
   );

   // Inputs change and outputs are sampled 1 time unit after a rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; init_start = 0; a_valid = 0; b_valid = 0;
      a_reg = 0; a_data = 0; b_reg = 0; b_data = 0;
      repeat (3) step();
      vectors++;
      if ({regwrite, wnum, wdata, init_busy, a_ready, b_ready} !== {1'b0, 3'd0, 8'd0, 1'b1, 1'b0, 1'b0}) begin
         miscompares++;
         $display("FAIL reset_state got we=%b num=%0d data=%h busy=%b rdy=%b%b exp 0/0/00/1/00",
                  regwrite, wnum, wdata, init_busy, a_ready, b_ready);
      end
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step();
         vectors++;
         if ({regwrite, wnum, wdata} !== {1'b1, 3'(i), 8'(i)}) begin
            miscompares++;
            $display("FAIL init_write[%0d] got we=%b num=%0d data=%h exp 1/%0d/%h", i, regwrite, wnum, wdata, i, i);
         end
         vectors++;
         if ({init_busy, a_ready, b_ready} !== {(i < 7), 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL init_busy[%0d] got busy=%b rdy=%b%b exp %b/00", i, init_busy, a_ready, b_ready, i < 7);
         end
      end
      step();
      vectors++;
      if (regwrite !== 1'b0) begin
         miscompares++;
         $display("FAIL init_end_we got %b exp 0", regwrite);
      end
   endtask

   task automatic test_single_a();
      a_valid = 1; a_reg = 3'd5; a_data = 8'hA5;
      #1;
      vectors++;
      if ({a_ready, b_ready} !== 2'b10) begin
         miscompares++;
         $display("FAIL single_a_ready got %b%b exp 10", a_ready, b_ready);
      end
      step();
      a_valid = 0;
      vectors++;
      if ({regwrite, wnum, wdata} !== {1'b1, 3'd5, 8'hA5}) begin
         miscompares++;
         $display("FAIL single_a_write got %b/%0d/%h exp 1/5/a5", regwrite, wnum, wdata);
      end
      step();
      vectors++;
      if ({regwrite, wnum, wdata} !== {1'b0, 3'd5, 8'hA5}) begin
         miscompares++;
         $display("FAIL single_a_idle got %b/%0d/%h exp 0/5/a5 (hold)", regwrite, wnum, wdata);
      end
   endtask

   task automatic test_single_b();
      b_valid = 1; b_reg = 3'd6; b_data = 8'h66;
      #1;
      vectors++;
      if ({a_ready, b_ready} !== 2'b01) begin
         miscompares++;
         $display("FAIL single_b_ready got %b%b exp 01", a_ready, b_ready);
      end
      step();
      b_valid = 0;
      vectors++;
      if ({regwrite, wnum, wdata} !== {1'b1, 3'd6, 8'h66}) begin
         miscompares++;
         $display("FAIL single_b_write got %b/%0d/%h exp 1/6/66", regwrite, wnum, wdata);
      end
      step();
   endtask

   // Pointer is B here, so A wins first.
   task automatic test_back_to_back();
      a_valid = 1; a_reg = 3'd1; a_data = 8'h11;
      b_valid = 1; b_reg = 3'd2; b_data = 8'h22;
      for (int k = 0; k < 4; k++) begin
         #1;
         vectors++;
         if ({a_ready, b_ready} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin
            miscompares++;
            $display("FAIL b2b_grant[%0d] got %b%b exp %s", k, a_ready, b_ready, (k % 2 == 0) ? "10" : "01");
         end
         step();
         vectors++;
         if ((k % 2 == 0) ? ({regwrite, wnum, wdata} !== {1'b1, 3'd1, 8'h11})
                          : ({regwrite, wnum, wdata} !== {1'b1, 3'd2, 8'h22})) begin
            miscompares++;
            $display("FAIL b2b_write[%0d] got %b/%0d/%h exp %s", k, regwrite, wnum, wdata,
                     (k % 2 == 0) ? "1/1/11" : "1/2/22");
         end
      end
      a_valid = 0; b_valid = 0;
      step();
   endtask

   task automatic test_init_start();
      b_valid = 1; b_reg = 3'd4; b_data = 8'h44; init_start = 1;
      #1;
      vectors++;
      if ({a_ready, b_ready} !== 2'b00) begin
         miscompares++;
         $display("FAIL initstart_ready got %b%b exp 00", a_ready, b_ready);
      end
      step();
      init_start = 0;
      vectors++;
      if ({regwrite, init_busy} !== 2'b01) begin
         miscompares++;
         $display("FAIL initstart_enter got we=%b busy=%b exp 0/1", regwrite, init_busy);
      end
      for (int i = 0; i < 8; i++) begin
         vectors++;
         if ({b_ready, init_busy} !== 2'b01) begin
            miscompares++;
            $display("FAIL reinit_ready[%0d] got rdy=%b busy=%b exp 0/1", i, b_ready, init_busy);
         end
         step();
         vectors++;
         if ({regwrite, wnum, wdata} !== {1'b1, 3'(i), 8'(i)}) begin
            miscompares++;
            $display("FAIL reinit_write[%0d] got %b/%0d/%h exp 1/%0d/%h", i, regwrite, wnum, wdata, i, i);
         end
      end
      vectors++;
      if ({b_ready, init_busy} !== 2'b10) begin
         miscompares++;
         $display("FAIL reinit_run got rdy=%b busy=%b exp 1/0", b_ready, init_busy);
      end
      step();
      b_valid = 0;
      vectors++;
      if ({regwrite, wnum, wdata} !== {1'b1, 3'd4, 8'h44}) begin
         miscompares++;
         $display("FAIL reinit_pending_b got %b/%0d/%h exp 1/4/44", regwrite, wnum, wdata);
      end
      step();
   endtask

   task automatic test_reset_midrun();
      a_valid = 1; a_reg = 3'd3; a_data = 8'h33;
      #1;
      vectors++;
      if (a_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL midrun_ready got %b exp 1", a_ready);
      end
      step();
      a_valid = 0;
      vectors++;
      if ({regwrite, wnum} !== {1'b1, 3'd3}) begin
         miscompares++;
         $display("FAIL midrun_write got %b/%0d exp 1/3", regwrite, wnum);
      end
      rst_n = 0;
      #1;
      vectors++;
      if ({regwrite, wnum, wdata, init_busy} !== {1'b0, 3'd0, 8'd0, 1'b1}) begin
         miscompares++;
         $display("FAIL midrun_reset_kill got %b/%0d/%h busy=%b exp 0/0/00/1", regwrite, wnum, wdata, init_busy);
      end
      step();
      rst_n = 1;
      for (int i = 0; i < 8; i++) begin
         step();
         vectors++;
         if ({regwrite, wnum, wdata} !== {1'b1, 3'(i), 8'(i)}) begin
            miscompares++;
            $display("FAIL restart_write[%0d] got %b/%0d/%h exp 1/%0d/%h", i, regwrite, wnum, wdata, i, i);
         end
      end
      step();
      vectors++;
      if ({regwrite, init_busy} !== 2'b00) begin
         miscompares++;
         $display("FAIL restart_done got we=%b busy=%b exp 0/0", regwrite, init_busy);
      end
   endtask

   initial begin
      test_reset();
      test_single_a();
      test_single_b();
      test_back_to_back();
      test_init_start();
      test_reset_midrun();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/regfile_write_sequencer.md
# regfile_write_sequencer

Owns the single write port of the 8-entry, 8-bit `Register_File` and shares it between two writeback requesters: A (ALU result) and B (load/immediate path). After reset, or on request, it sequences a deterministic initialisation that writes register i with value i. The block sits between the writeback stage and the register file's `RegWrite` / `Write_Reg_Num` / `Write_Data` inputs.

## Interface
- `DATA_W`, default 8: register data width.
- `ADDR_W`, default 3: register number width.
- `NUM_REGS`, default 8: registers to initialise. Must be ≤ 2^ADDR_W, and DATA_W ≥ ADDR_W.

Ports:
- `Clk`  in  1  sole clock, rising edge.
- `Reset`  in  1  reset, asynchronous, active-low.
- `Init_Start`  in  1  request re-initialisation. Honoured only in RUN.
- `A_Valid`  in  1  requester A has a write pending.
- `A_Reg`  in  ADDR_W  A target register.
- `A_Data`  in  DATA_W  A write data.
- `A_Ready`  out  1  A accepted this cycle (combinational).
- `B_Valid`, `B_Reg`, `B_Data`, `B_Ready`: as for A, for requester B.
- `RegWrite`  out  1  registered write strobe to the register file.
- `Write_Reg_Num`  out  ADDR_W  registered write address.
- `Write_Data`  out  DATA_W  registered write data.
- `Init_Busy`  out  1  high while the state is INIT.

## Operation
- States:
  - INIT: walk counter `cnt` across 0..NUM_REGS-1.
  - RUN: arbitrate between A and B.
- Reset asserted (low):
  - state=INIT, cnt=0, last-grant pointer=B (so A wins first).
  - RegWrite=0, Write_Reg_Num=0, Write_Data=0.
  - Init_Busy=1, A_Ready=B_Ready=0.
- INIT, each edge:
  - Output regs load RegWrite=1, Write_Reg_Num=cnt, Write_Data=cnt zero-extended; cnt increments.
  - On the edge where cnt=NUM_REGS-1, state→RUN and cnt→0.
  - A_Ready and B_Ready are forced to 0 throughout.
  - Init_Start is ignored.
- RUN:
  - Grant rule:
    - Only one valid: grant it.
    - Both valid: grant the one not granted last.
    - Neither valid: no grant.
  - Ready of the granted requester is 1. At most one Ready is high in any cycle.
  - Accept = Valid & Ready. On an accepting edge, the output regs load RegWrite=1 and that requester's Reg/Data, and the pointer updates to the granted requester.
  - No accept: RegWrite loads 0. Address and data registers hold.
- Init_Start=1 in RUN:
  - Both Ready are forced to 0 that cycle.
  - At the next edge, state→INIT, cnt=0, RegWrite loads 0.
- Requesters hold Valid, Reg and Data stable until accepted. The sequencer never drops an accepted write.
- A and B may target the same register. Writes land in grant order, so the later grant wins.

## Timing
- Write latency: accepted at edge t, RegWrite=1 in the cycle after edge t, for exactly one cycle per accept.
- Throughput: one write per cycle. With both requesters permanently valid, grants alternate A, B, A, …
- Initialisation sequence after reset release:
  - Edges 1..NUM_REGS produce writes to registers 0..NUM_REGS-1.
  - Init_Busy drops after edge NUM_REGS.
  - First accept is possible at edge NUM_REGS+1.
- Reset asserted mid-INIT or mid-RUN: immediate return to reset values. Any in-flight output write is killed (RegWrite=0 asynchronously).
- Init_Start and a Valid in the same cycle: no accept. The request stays pending until INIT completes.

## Structure
- Package `regfile_pkg` holds:
  - State enum {ST_INIT, ST_RUN}.
  - Default DATA_W, ADDR_W, NUM_REGS constants.
  - Requester index constants REQ_A=0, REQ_B=1.
- Sub-module `rr_arbiter2`: combinational two-way round-robin grant from {A_Valid, B_Valid, last_grant, enable}. The parent owns the last-grant register.
- Top level holds the FSM, the walk counter and the output registers.

## Test plan
- Reset low for 3 cycles, then release with no requests:
  - RegWrite pulses for 8 consecutive cycles with (Num, Data) = (0,0) … (7,7).
  - Init_Busy falls after the 8th edge; Readies stay 0 throughout.
- In RUN, A_Valid with A_Reg=5, A_Data=0xA5 alone:
  - A_Ready=1 the same cycle.
  - Next cycle RegWrite=1, Num=5, Data=0xA5; the following cycle RegWrite=0.
- A and B both held valid for 4 cycles, with A→(1,0x11) and B→(2,0x22) re-presented after each accept:
  - Grants go A, B, A, B.
  - The output write sequence alternates reg1/0x11 and reg2/0x22.
- Init_Start pulsed for one cycle while B_Valid=1:
  - B_Ready=0 that cycle, then the 8-write init sequence runs.
  - B is accepted at the first RUN cycle and its write appears immediately after reg7.
- Reset asserted on the cycle after an accept of A→(3,0x33):
  - RegWrite=0 immediately, with no write to reg3.
  - Init restarts at reg0 after reset release.
